// File: rtl/mgmt_multitimer.sv
// mgmt_multitimer: NCHAN independent counter/timer channels behind a single-cycle CSR port.
//
// Each channel has a WIDTH-bit VALUE counter with a RELOAD register, a PRE_W-bit prescaler,
// up/down counting, one-shot or periodic mode and a maskable pending interrupt.
//
// Ports:
//   sys_clk    - single clock
//   sys_rst    - asynchronous, active-high reset
//   csr_adr    - word address {chan, reg[2:0]}
//   csr_we     - write strobe, one cycle per write
//   csr_dat_w  - write data (truncated to WIDTH / PRE_W)
//   csr_dat_r  - registered read data for the address presented one cycle earlier
//   tick_o     - per-channel one-cycle pulse, high the cycle after a terminal event
//   irq        - OR over channels of (pending & irq_en)
//
// Register map per channel:
//   0 LOAD     write sets VALUE immediately; reads return the live VALUE
//   1 RELOAD
//   2 CTRL     bit0 en, bit1 periodic, bit2 up, bit3 irq_en, bits[8 +: PRE_W] prescale
//   3 VALUE    read-only live count
//   4 PENDING  bit0, write-1-to-clear
//   5..7       reserved, read 0
module mgmt_multitimer #(
  parameter int unsigned NCHAN = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PRE_W = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [$clog2(NCHAN)+2:0]   csr_adr,
  input  logic                       csr_we,
  input  logic [31:0]                csr_dat_w,
  output logic [31:0]                csr_dat_r,
  output logic [NCHAN-1:0]           tick_o,
  output logic                       irq
);

  localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [2:0] RegLoad    = 3'd0;
  localparam logic [2:0] RegReload  = 3'd1;
  localparam logic [2:0] RegCtrl    = 3'd2;
  localparam logic [2:0] RegValue   = 3'd3;
  localparam logic [2:0] RegPending = 3'd4;

  logic [2:0]       reg_sel;
  logic [CW-1:0]    chan_sel;
  logic             chan_ok;
  logic [31:0]      chan_word [NCHAN];
  logic [NCHAN-1:0] irq_vec;
  logic [31:0]      rdata;

  // Address decode; chan_ok guards against non-power-of-two channel counts.
  always_comb begin
    reg_sel  = csr_adr[2:0];
    chan_sel = CW'(csr_adr >> 3);
    chan_ok  = (32'(chan_sel) < NCHAN);
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] reload_q;
    logic [PRE_W-1:0] pre_cfg_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic             en_q;
    logic             periodic_q;
    logic             up_q;
    logic             irq_en_q;
    logic             pending_q;
    logic             tick_q;

    logic             sel;
    logic             load_we;
    logic             reload_we;
    logic             ctrl_we;
    logic             pend_we;
    logic             tick_int;
    logic             terminal;
    logic             step;
    logic             fire;
    logic [31:0]      word;

    always_comb begin
      sel       = csr_we && chan_ok && (chan_sel == CW'(c));
      load_we   = sel && (reg_sel == RegLoad);
      reload_we = sel && (reg_sel == RegReload);
      ctrl_we   = sel && (reg_sel == RegCtrl);
      pend_we   = sel && (reg_sel == RegPending);
      tick_int  = en_q && (pre_cnt_q == pre_cfg_q);
      terminal  = up_q ? (value_q == reload_q) : (value_q == '0);
      // A LOAD or CTRL write in the same cycle swallows the prescaler tick.
      step      = tick_int && !load_we && !ctrl_we;
      fire      = step && terminal;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        value_q    <= '0;
        reload_q   <= '0;
        pre_cfg_q  <= '0;
        pre_cnt_q  <= '0;
        en_q       <= 1'b0;
        periodic_q <= 1'b0;
        up_q       <= 1'b0;
        irq_en_q   <= 1'b0;
        pending_q  <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        tick_q <= fire;

        if (ctrl_we || !en_q || tick_int) begin
          pre_cnt_q <= '0;
        end else begin
          pre_cnt_q <= pre_cnt_q + PRE_W'(1);
        end

        if (reload_we) begin
          reload_q <= csr_dat_w[WIDTH-1:0];
        end

        if (load_we) begin
          value_q <= csr_dat_w[WIDTH-1:0];
        end else if (step) begin
          if (terminal) begin
            // One-shot holds the terminal value.
            if (periodic_q) value_q <= up_q ? '0 : reload_q;
          end else if (up_q) begin
            value_q <= value_q + WIDTH'(1);
          end else begin
            value_q <= value_q - WIDTH'(1);
          end
        end

        // A CTRL write always wins over the one-shot self-disable.
        if (ctrl_we) begin
          en_q       <= csr_dat_w[0];
          periodic_q <= csr_dat_w[1];
          up_q       <= csr_dat_w[2];
          irq_en_q   <= csr_dat_w[3];
          pre_cfg_q  <= csr_dat_w[8 +: PRE_W];
        end else if (fire && !periodic_q) begin
          en_q <= 1'b0;
        end

        // A new event beats a simultaneous clear.
        if (fire) begin
          pending_q <= 1'b1;
        end else if (pend_we && csr_dat_w[0]) begin
          pending_q <= 1'b0;
        end
      end
    end

    always_comb begin
      word = '0;
      case (reg_sel)
        RegLoad, RegValue: word = 32'(value_q);
        RegReload:         word = 32'(reload_q);
        RegCtrl: begin
          word[8 +: PRE_W] = pre_cfg_q;
          word[3:0]        = {irq_en_q, up_q, periodic_q, en_q};
        end
        RegPending:        word[0] = pending_q;
        default:           word = '0;
      endcase
    end

    assign chan_word[c] = word;
    assign irq_vec[c]   = pending_q && irq_en_q;
    assign tick_o[c]    = tick_q;
  end

  always_comb begin
    rdata = '0;
    if (chan_ok) rdata = chan_word[chan_sel];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      csr_dat_r <= '0;
    end else begin
      csr_dat_r <= rdata;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: doc/mgmt_multitimer.md
# mgmt_multitimer

Parametrised multi-channel counter/timer for the management SoC, the successor of the single 32-bit countdown timer. It provides NCHAN independent channels, each with programmable width, prescaler, count direction, one-shot or periodic mode, and a maskable interrupt. Channels are aggregated onto one IRQ line and a single-cycle CSR port on the management bus side. Per-channel tick pulses can be routed to the logic analyzer outputs for bench observation.

## Interface
- NCHAN, 4: number of channels, 1..8.
- WIDTH, 32: counter width, 8..32.
- PRE_W, 8: prescaler width.

- sys_clk  in  1  single clock domain.
- sys_rst  in  1  asynchronous, active-high reset.
- csr_adr  in  clog2(NCHAN)+3  word address {chan, reg[2:0]}.
- csr_we  in  1  write strobe, one cycle per write.
- csr_dat_w  in  32  write data.
- csr_dat_r  out  32  read data, registered.
- tick_o  out  NCHAN  one-cycle pulse per channel event.
- irq  out  1  OR over channels of (pending & irq_en).

## Operation
- Per-channel registers (reg index):
  - 0 LOAD: write sets VALUE immediately.
  - 1 RELOAD.
  - 2 CTRL: bit0 en, bit1 periodic, bit2 up, bit3 irq_en, bits[8+PRE_W-1:8] prescale.
  - 3 VALUE: read-only, live count.
  - 4 PENDING: bit0, write-1-to-clear.
  - 5..7: reserved, read 0, writes ignored.
- Reads zero-extend to 32 bits; writes truncate to WIDTH or PRE_W.
- Prescaler:
  - While en=1, emits an internal tick every prescale+1 sys_clk cycles; prescale=0 gives a tick every cycle.
  - Prescale counter clears on any CTRL write and while en=0.
- On a tick the channel tests VALUE against its terminal value: 0 in down mode, RELOAD in up mode.
  - Not terminal: VALUE decrements (down) or increments (up).
  - Terminal: event. Sets PENDING and pulses tick_o.
    - periodic=1: VALUE loads RELOAD (down) or 0 (up). The period is RELOAD+1 ticks.
    - periodic=0: hardware clears en and VALUE holds the terminal value.
- en=0: VALUE freezes. Setting en=1 resumes from the current VALUE.
- Up mode with VALUE > RELOAD: counts up, wraps at 2^WIDTH-1 → 0, then reaches RELOAD.
- Down mode with RELOAD=0, periodic: an event occurs on every tick.

## Timing
- Reset values: every register 0, csr_dat_r=0, tick_o=0, irq=0.
- Writes take effect at the clock edge where csr_we=1.
- Read data for csr_adr appears on csr_dat_r one cycle later. Reads have no side effects.
- Event:
  - PENDING and VALUE update at the tick edge.
  - tick_o is high for exactly the cycle following that edge.
  - irq is combinational from PENDING/irq_en flops, so it rises in the same cycle as tick_o.
- Simultaneous events:
  - LOAD write coinciding with a tick: the write wins, no decrement and no event that cycle.
  - CTRL write coinciding with a tick: the tick is discarded.
  - PENDING clear coinciding with a new event: set wins.
  - One-shot terminal coinciding with a CTRL write of en=1: the write wins and the channel keeps running.
- Reset asserted mid-count: all state clears asynchronously and irq drops immediately. Counting restarts only after software reprograms the channel.
- Channels are fully independent. Several channels may pend in the same cycle.

## Test plan
- Reset / defaults: assert sys_rst mid-count → all reads 0, irq=0 and tick_o=0 within the reset cycle.
- Down, one-shot:
  - Stimulus: ch0 LOAD=5, CTRL=0x09 (en, irq_en, prescale 0).
  - Required: VALUE reads 5,4,3,2,1,0; event on the 6th tick; irq=1; CTRL reads 0x08.
  - Then write PENDING=1 → irq=0 the next cycle.
- Periodic up with prescaler:
  - Stimulus: ch1 RELOAD=3, LOAD=0, CTRL=0x0207 (prescale 2).
  - Required: tick_o[1] pulses every 12 sys_clk cycles for at least 4 periods.
- Width and wrap:
  - Stimulus: WIDTH=8, up mode, LOAD=0xFE, RELOAD=0x01, periodic.
  - Required: VALUE sequence FE, FF, 00, 01, then event.
  - A write of 0x1234 to LOAD reads back 0x34.
- Collisions:
  - LOAD write in the cycle of a terminal tick → no event, VALUE=new LOAD.
  - PENDING clear coincident with an event → PENDING stays 1.
- Multi-channel:
  - Stimulus: all channels periodic, each with a different RELOAD.
  - Required: each tick_o count matches its expected period; irq follows only irq_en channels; reserved addresses read 0.
